dsp48_input_pipe: RTL

- Parametrised successor to the DSP48A1 A/B/C/D input register stage.
- Each of the four operand channels gets a configurable register depth from 0 to 4 stages, its own clock enable and its own synchronous active-low reset.
- The B channel source can be selected at runtime, and the stage drives a B cascade output.
- Each channel reports a fill flag once its pipeline holds real data since the last reset.
- Sits between the DSP operand ports and the pre-adder/multiplier datapath.

---
 rtl/dsp48_input_pipe.sv | 121 ++++++++++++
 1 files changed

// File: rtl/dsp48_input_pipe.sv
// DSP48-style A/B/C/D operand register stage.
// Per-channel depth 0..4, clock enable, sync reset and fill flag.
module dsp48_input_pipe #(
  parameter int    A_DEPTH = 1,
  parameter int    B_DEPTH = 1,
  parameter int    C_DEPTH = 1,
  parameter int    D_DEPTH = 1,
  parameter string B_INPUT = "DIRECT",
  parameter int    WIDTH   = 18,
  parameter int    C_WIDTH = 48
) (
  input  logic               clk,
  input  logic               rsta_n,
  input  logic               rstb_n,
  input  logic               rstc_n,
  input  logic               rstd_n,
  input  logic               cea,
  input  logic               ceb,
  input  logic               cec,
  input  logic               ced,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   d,
  input  logic [WIDTH-1:0]   BCIN,
  input  logic [C_WIDTH-1:0] c,
  input  logic               bsel,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic [WIDTH-1:0]   d_out,
  output logic [C_WIDTH-1:0] c_out,
  output logic [WIDTH-1:0]   BCOUT,
  output logic               a_full,
  output logic               b_full,
  output logic               c_full,
  output logic               d_full
);

  logic [WIDTH-1:0] b_src;
  logic             unused_src;

  // Unknown source modes feed zeros but keep the registers live
  if (B_INPUT == "DIRECT") begin : g_bdir
    assign b_src = b;
  end else if (B_INPUT == "CASCADE") begin : g_bcas
    assign b_src = BCIN;
  end else if (B_INPUT == "DYNAMIC") begin : g_bdyn
    assign b_src = bsel ? BCIN : b;
  end else begin : g_bzero
    assign b_src = '0;
  end

  assign unused_src = ^{bsel, BCIN, b};
  assign BCOUT      = b_out;

  for (genvar k = 0; k < 4; k++) begin : g_ch
    localparam int DEP = (k == 0) ? A_DEPTH :
                         (k == 1) ? B_DEPTH :
                         (k == 2) ? C_DEPTH : D_DEPTH;
    localparam int W   = (k == 2) ? C_WIDTH : WIDTH;

    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         rst_n;
    logic         ce;
    logic         full;

    if (k == 0) begin : g_io
      assign din    = a;
      assign rst_n  = rsta_n;
      assign ce     = cea;
      assign a_out  = dout;
      assign a_full = full;
    end else if (k == 1) begin : g_io
      assign din    = b_src;
      assign rst_n  = rstb_n;
      assign ce     = ceb;
      assign b_out  = dout;
      assign b_full = full;
    end else if (k == 2) begin : g_io
      assign din    = c;
      assign rst_n  = rstc_n;
      assign ce     = cec;
      assign c_out  = dout;
      assign c_full = full;
    end else begin : g_io
      assign din    = d;
      assign rst_n  = rstd_n;
      assign ce     = ced;
      assign d_out  = dout;
      assign d_full = full;
    end

    if (DEP == 0) begin : g_pass
      logic unused_ctl;
      assign dout       = din;
      assign full       = 1'b1;
      assign unused_ctl = ^{rst_n, ce};
    end else begin : g_reg
      localparam logic [2:0] DMAX = 3'(DEP);

      logic [W-1:0] stg [DEP];
      logic [2:0]   cnt;

      // Whole chain moves together; no partial shifts
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEP; i++) stg[i] <= '0;
          cnt <= '0;
        end else if (ce) begin
          stg[0] <= din;
          for (int i = 1; i < DEP; i++) stg[i] <= stg[i-1];
          if (cnt != DMAX) cnt <= cnt + 3'd1;
        end
      end

      assign dout = stg[DEP-1];
      assign full = (cnt == DMAX);
    end
  end

endmodule
